code_frame_decoder: RTL

Sequential receive end of the encoder/decoder link. It accepts a stream of 3-bit codes, one per beat, each with a Good qualifier and a frame-end marker, and rebuilds the 8-bit multi-hot vector the sender serialised. It presents each completed vector on a valid/ready output together with a set-bit count and a duplicate-code flag. It sits downstream of the serialising encoder and replaces the purely combinational decode path when the link is time-multiplexed.

---
 rtl/enc_dec_pkg.sv | 13 +
 rtl/code_frame_decoder_dec.sv | 18 +
 rtl/code_frame_decoder.sv | 113 +++++++++++
 3 files changed

// File: rtl/enc_dec_pkg.sv
// Shared constants and FSM state encoding for the code encoder/decoder link.
package enc_dec_pkg;

  localparam int VEC_WIDTH = 8;   // width of the multi-hot vector
  localparam int CODE_W    = 3;   // code width, clog2(VEC_WIDTH)
  localparam int CNT_W     = 4;   // set-bit count width, holds 0..VEC_WIDTH

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/code_frame_decoder_dec.sv
// Code-to-one-hot decoder: sets bit i_code of the output when i_good is 1,
// otherwise the output is all zeros.
module code_frame_decoder_dec #(
  parameter int WIDTH = 8,
  parameter int CW    = 3
) (
  input  logic [CW-1:0]    i_code,
  input  logic             i_good,
  output logic [WIDTH-1:0] o_onehot
);

  // One-hot expansion gated by the qualifier
  always_comb begin
    o_onehot = '0;
    if (i_good) o_onehot[i_code] = 1'b1;
  end

endmodule

// File: rtl/code_frame_decoder.sv
// Frame-based receive decoder: ORs one-hot codes into an accumulator over a
// frame and presents the merged vector, its set-bit count and a duplicate
// flag on a valid/ready output holding register.
import enc_dec_pkg::*;

module code_frame_decoder #(
  parameter int WIDTH = VEC_WIDTH,
  parameter int CW    = CODE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_code,
  input  logic             in_good,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_count,
  output logic             out_dup
);

  state_t             r_state;
  logic [WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]   r_acc_cnt;
  logic               r_acc_dup;

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [CNT_W-1:0]   r_out_count;
  logic               r_out_dup;

  logic [WIDTH-1:0]   w_onehot;
  logic               w_fire;
  logic               w_close;
  logic               w_hit;
  logic               w_new;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_dup_nxt;

  code_frame_decoder_dec #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_dec (
    .i_code   (in_code),
    .i_good   (in_good),
    .o_onehot (w_onehot)
  );

  // Input is stalled whenever an unconsumed result is held, so accumulation
  // never runs ahead of the output register.
  assign in_ready = !r_out_valid || out_ready;
  assign w_fire   = in_valid && in_ready;
  assign w_close  = w_fire && in_last;

  // Merge of the current beat into the accumulator (includes the last beat)
  always_comb begin
    w_hit     = |(r_acc & w_onehot);
    w_new     = in_good && !w_hit;
    w_acc_nxt = r_acc | w_onehot;
    w_cnt_nxt = r_acc_cnt + CNT_W'(w_new);
    w_dup_nxt = r_acc_dup | w_hit;
  end

  // Accumulator FSM: collects beats, clears when the frame closes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_acc_cnt <= '0;
      r_acc_dup <= 1'b0;
    end else if (w_fire) begin
      case (r_state)
        ST_IDLE:  r_state <= in_last ? ST_IDLE : ST_ACCUM;
        ST_ACCUM: r_state <= in_last ? ST_IDLE : ST_ACCUM;
      endcase
      if (in_last) begin
        r_acc     <= '0;
        r_acc_cnt <= '0;
        r_acc_dup <= 1'b0;
      end else begin
        r_acc     <= w_acc_nxt;
        r_acc_cnt <= w_cnt_nxt;
        r_acc_dup <= w_dup_nxt;
      end
    end
  end

  // Output holding register: loads on frame close, drops when consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_dup   <= 1'b0;
    end else if (w_close) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_acc_nxt;
      r_out_count <= w_cnt_nxt;
      r_out_dup   <= w_dup_nxt;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_dup   = r_out_dup;

endmodule
